// File: rtl/tqvp_segment_reader.sv
// Seven-segment read-back peripheral: synchronises segment lines, filters for stability,
// decodes accepted patterns to hex digits and queues every change in a 4-entry FIFO.
module tqvp_segment_reader (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   logic       r_en, r_mo, r_al;
   logic [7:0] r_filt;
   logic [6:0] r_s1, r_s2;
   logic [6:0] r_prev;
   logic [7:0] r_cnt;
   logic       r_acc_valid;
   logic [6:0] r_acc_pat;
   logic [7:0] r_cur;
   logic [7:0] r_fifo [4];
   logic [1:0] r_wp, r_rp;
   logic [2:0] r_count;
   logic       r_ovf;

   logic [6:0] w_seg;
   logic [7:0] w_thr, w_new_thr;
   logic       w_wr_ctrl, w_wr_filt, w_pop, w_wr_stat;
   logic       w_disable, w_accept, w_flush;
   logic       w_full, w_empty, w_pop_ok, w_push_ok;
   logic [7:0] w_dec;
   logic [6:0] w_prev_nxt;
   logic [7:0] w_cnt_nxt;

   assign w_seg     = r_s2 ^ {7{r_al}};
   assign w_thr     = (r_filt == 8'd0) ? 8'd1 : r_filt;
   assign w_new_thr = (data_in == 8'd0) ? 8'd1 : data_in;
   assign w_wr_ctrl = data_write && (address == 4'h0);
   assign w_wr_filt = data_write && (address == 4'h1);
   assign w_pop     = data_write && (address == 4'h4);
   assign w_wr_stat = data_write && (address == 4'h5);
   assign w_disable = w_wr_ctrl && !data_in[7];
   assign w_flush   = w_wr_stat && data_in[3];
   assign w_full    = (r_count == 3'd4);
   assign w_empty   = (r_count == 3'd0);
   assign w_pop_ok  = w_pop && !w_empty;
   // A disabling write wins over an accept landing on the same edge.
   assign w_accept  = r_en && !w_disable && (r_cnt == w_thr)
                      && (!r_acc_valid || (r_prev != r_acc_pat));
   assign w_push_ok = w_accept && (!w_full || w_pop_ok);

   always_comb begin
      w_dec = 8'hC0;
      case (r_prev)
         7'h3F: w_dec = 8'h80;
         7'h06: w_dec = 8'h81;
         7'h5B: w_dec = 8'h82;
         7'h4F: w_dec = 8'h83;
         7'h66: w_dec = 8'h84;
         7'h6D: w_dec = 8'h85;
         7'h7D: w_dec = 8'h86;
         7'h07, 7'h27: w_dec = 8'h87;
         7'h7F: w_dec = 8'h88;
         7'h6F, 7'h67: w_dec = 8'h89;
         7'h77: w_dec = 8'h8A;
         7'h7C: w_dec = 8'h8B;
         7'h39: w_dec = 8'h8C;
         7'h5E: w_dec = 8'h8D;
         7'h79: w_dec = 8'h8E;
         7'h71: w_dec = 8'h8F;
         7'h00: w_dec = 8'hA0;
         default: w_dec = 8'hC0;
      endcase
   end

   // A lowered threshold clamps the running count so a saturated count can still match.
   always_comb begin
      w_prev_nxt = r_prev;
      w_cnt_nxt  = r_cnt;
      if (r_en) begin
         if (w_seg != r_prev) begin
            w_prev_nxt = w_seg;
            w_cnt_nxt  = 8'd1;
         end else if (r_cnt < w_thr) begin
            w_cnt_nxt = r_cnt + 8'd1;
         end
      end
      if (w_wr_filt && (w_cnt_nxt > w_new_thr))
         w_cnt_nxt = w_new_thr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_en        <= 1'b0;
         r_mo        <= 1'b0;
         r_al        <= 1'b0;
         r_filt      <= 8'h04;
         r_s1        <= 7'h00;
         r_s2        <= 7'h00;
         r_prev      <= 7'h00;
         r_cnt       <= 8'h00;
         r_acc_valid <= 1'b0;
         r_acc_pat   <= 7'h00;
         r_cur       <= 8'h00;
         r_wp        <= 2'd0;
         r_rp        <= 2'd0;
         r_count     <= 3'd0;
         r_ovf       <= 1'b0;
      end else begin
         r_s1 <= ui_in[6:0];
         r_s2 <= r_s1;
         if (w_wr_ctrl) begin
            r_en <= data_in[7];
            r_mo <= data_in[6];
            r_al <= data_in[4];
         end
         if (w_wr_filt)
            r_filt <= data_in;
         if (w_disable) begin
            r_prev      <= 7'h00;
            r_cnt       <= 8'h00;
            r_acc_valid <= 1'b0;
            r_cur[7]    <= 1'b0;
         end else begin
            r_prev <= w_prev_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_accept) begin
               r_acc_pat   <= r_prev;
               r_acc_valid <= 1'b1;
               r_cur       <= w_dec;
            end
         end
         if (w_flush) begin
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_count <= 3'd0;
         end else begin
            if (w_pop_ok)
               r_rp <= r_rp + 2'd1;
            if (w_push_ok)
               r_wp <= r_wp + 2'd1;
            if (w_push_ok && !w_pop_ok)
               r_count <= r_count + 3'd1;
            else if (!w_push_ok && w_pop_ok)
               r_count <= r_count - 3'd1;
         end
         if (w_accept && !w_push_ok && !w_flush)
            r_ovf <= 1'b1;
         else if (w_wr_stat && data_in[2])
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !w_flush && w_push_ok)
         r_fifo[r_wp] <= w_dec;
   end

   assign uo_out = r_mo ? r_cur : 8'h00;

   always_comb begin
      data_out = 8'hFF;
      case (address)
         4'h0: data_out = {r_en, r_mo, 1'b0, r_al, 4'b0000};
         4'h1: data_out = r_filt;
         4'h2: data_out = r_cur;
         4'h3: data_out = {1'b0, w_seg};
         4'h4: data_out = w_empty ? 8'h00 : r_fifo[r_rp];
         4'h5: data_out = {r_count, w_full, w_empty, r_ovf, 2'b00};
         default: data_out = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_tqvp_segment_reader.sv
// Bench for tqvp_segment_reader: directed scenarios then random traffic, all checked
// against a queue-based reference model of the peripheral.
module tb_tqvp_segment_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   int checks = 0;
   int errors = 0;

   tqvp_segment_reader dut (
      .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
      .data_write(data_write), .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // reference model state
   logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   bit         m_en, m_mo, m_al, m_accv, m_ovf;
   logic [7:0] m_filt, m_cur;
   logic [6:0] m_s1, m_s2, m_prev, m_accpat;
   int         m_cnt;
   logic [7:0] m_q [$];

   function automatic logic [7:0] m_dec(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (p == pats[i]) return 8'h80 | 8'(i);
      if (p == 7'h27) return 8'h87;
      if (p == 7'h67) return 8'h89;
      if (p == 7'h00) return 8'hA0;
      return 8'hC0;
   endfunction

   function automatic logic [7:0] m_read(input logic [3:0] a);
      case (a)
         4'h0: return {m_en, m_mo, 1'b0, m_al, 4'b0000};
         4'h1: return m_filt;
         4'h2: return m_cur;
         4'h3: return {1'b0, m_s2 ^ {7{m_al}}};
         4'h4: return (m_q.size() > 0) ? m_q[0] : 8'h00;
         4'h5: return {3'(m_q.size()), m_q.size() == 4, m_q.size() == 0, m_ovf, 2'b00};
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_mo = 0; m_al = 0; m_accv = 0; m_ovf = 0;
      m_filt = 8'h04; m_cur = 8'h00;
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_accpat = 0; m_cnt = 0;
      m_q.delete();
   endtask

   // One clock edge of the peripheral's documented behaviour, from the current inputs.
   task automatic model_step();
      int         thr, nthr;
      logic [6:0] seg;
      bit         we_ctrl, we_filt, pop, we_stat, dis, acc;
      logic [7:0] entry;
      if (rst) begin
         model_reset();
      end else begin
         thr     = (m_filt == 0) ? 1 : int'(m_filt);
         seg     = m_s2 ^ {7{m_al}};
         we_ctrl = data_write && address == 4'h0;
         we_filt = data_write && address == 4'h1;
         pop     = data_write && address == 4'h4;
         we_stat = data_write && address == 4'h5;
         dis     = we_ctrl && !data_in[7];
         acc     = m_en && !dis && m_cnt == thr && (!m_accv || m_prev != m_accpat);
         entry   = m_dec(m_prev);
         if (acc) begin
            m_accpat = m_prev;
            m_accv   = 1;
            m_cur    = entry;
         end
         if (m_en) begin
            if (seg != m_prev) begin
               m_prev = seg;
               m_cnt  = 1;
            end else if (m_cnt < thr) begin
               m_cnt++;
            end
         end
         if (we_stat && data_in[2]) m_ovf = 0;
         if (we_stat && data_in[3]) begin
            m_q.delete();
         end else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
               if (m_q.size() < 4) m_q.push_back(entry);
               else m_ovf = 1;
            end
         end
         if (we_ctrl) begin
            m_en = data_in[7]; m_mo = data_in[6]; m_al = data_in[4];
         end
         if (dis) begin
            m_cnt = 0; m_prev = 0; m_accv = 0; m_cur[7] = 1'b0;
         end
         if (we_filt) begin
            m_filt = data_in;
            nthr   = (data_in == 0) ? 1 : int'(data_in);
            if (m_cnt > nthr) m_cnt = nthr;
         end
         m_s2 = m_s1;
         m_s1 = ui_in[6:0];
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cyc(input bit has_exp, input logic [7:0] exp, input string tag);
      #1;
      if (has_exp) chk(tag, data_out, exp);
      chk("rd_model", data_out, m_read(address));
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("uo_model", uo_out, m_mo ? m_cur : 8'h00);
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
      address = a;
      cyc(1'b1, exp, tag);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address = a; data_in = d; data_write = 1'b1;
      cyc(1'b0, 8'h00, "wr");
      data_write = 1'b0;
      address = 4'h2;
   endtask

   task automatic hold(input int n);
      repeat (n) cyc(1'b0, 8'h00, "hold");
   endtask

   logic [7:0] ov_pats [5] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};

   initial begin
      int hld, r, k;
      rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      cyc(1'b0, 8'h00, "rst");
      rst = 1'b0;

      // reset defaults
      rd(4'h0, 8'h00, "rst_ctrl");
      rd(4'h1, 8'h04, "rst_filt");
      rd(4'h2, 8'h00, "rst_cur");
      rd(4'h5, 8'h08, "rst_stat");
      rd(4'h9, 8'hFF, "rst_unmapped");
      chk("rst_uo", uo_out, 8'h00);

      // basic decode with exact acceptance edge
      wr(4'h0, 8'h80);
      ui_in = 8'h5B; address = 4'h2;
      repeat (6) cyc(1'b0, 8'h00, "wait");
      cyc(1'b1, 8'h00, "cur_e5");
      cyc(1'b1, 8'h82, "cur_e6");
      rd(4'h4, 8'h82, "head_2");
      rd(4'h5, 8'h20, "stat_cnt1");

      // glitch rejection and alternate encodings
      wr(4'h4, 8'h00);
      ui_in = 8'h07; hold(2);
      ui_in = 8'h6F; hold(10);
      rd(4'h2, 8'h89, "cur_9");
      rd(4'h5, 8'h20, "glitch_cnt");
      rd(4'h4, 8'h89, "head_9");
      ui_in = 8'h67; hold(10);
      rd(4'h2, 8'h89, "cur_9alt");
      rd(4'h5, 8'h40, "cnt_9alt");
      wr(4'h0, 8'h90);
      ui_in = 8'h40; hold(10);
      rd(4'h2, 8'h80, "cur_al0");
      rd(4'h3, 8'h3F, "raw_al");

      // error and blank
      wr(4'h0, 8'h80);
      ui_in = 8'h01; hold(10);
      rd(4'h2, 8'hC0, "cur_err");
      ui_in = 8'h00; hold(10);
      rd(4'h2, 8'hA0, "cur_blank");
      wr(4'h5, 8'h0C);
      rd(4'h5, 8'h08, "stat_flush1");

      // overflow, then pop coinciding with an accept
      for (int i = 0; i < 5; i++) begin
         ui_in = ov_pats[i]; hold(9);
      end
      rd(4'h5, 8'h94, "stat_ovf");
      rd(4'h4, 8'h81, "head_first");
      ui_in = 8'h7D; address = 4'h2;
      repeat (6) cyc(1'b0, 8'h00, "wait");
      wr(4'h4, 8'h00);
      rd(4'h5, 8'h94, "stat_pushpop");
      rd(4'h4, 8'h82, "drain_2");
      wr(4'h4, 8'h00);
      rd(4'h4, 8'h83, "drain_3");
      wr(4'h4, 8'h00);
      rd(4'h4, 8'h84, "drain_4");
      wr(4'h4, 8'h00);
      rd(4'h4, 8'h86, "drain_6");
      wr(4'h5, 8'h0C);
      rd(4'h5, 8'h08, "stat_flush2");

      // disable and mirror
      wr(4'h0, 8'hC0);
      ui_in = 8'h4F; hold(10);
      chk("mirror_on", uo_out, 8'h83);
      rd(4'h5, 8'h20, "mirror_cnt");
      wr(4'h0, 8'h40);
      chk("mirror_dis", uo_out, 8'h03);
      rd(4'h5, 8'h20, "dis_fifo");
      wr(4'h0, 8'hC0);
      hold(10);
      chk("mirror_reacc", uo_out, 8'h83);
      rd(4'h5, 8'h40, "reacc_cnt");

      // FILT = 0 behaves as a threshold of one
      wr(4'h1, 8'h00);
      rd(4'h1, 8'h00, "filt0");
      ui_in = 8'h7F; address = 4'h2;
      repeat (3) cyc(1'b0, 8'h00, "wait");
      cyc(1'b1, 8'h83, "thr1_e2");
      cyc(1'b1, 8'h88, "thr1_e3");

      // random traffic against the model
      hld = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hld == 0) begin
            k = $urandom_range(0, 19);
            if (k < 16)       ui_in[6:0] = pats[k];
            else if (k == 16) ui_in[6:0] = 7'h27;
            else if (k == 17) ui_in[6:0] = 7'h67;
            else if (k == 18) ui_in[6:0] = 7'h00;
            else              ui_in[6:0] = 7'($urandom);
            ui_in[6:0] = ui_in[6:0] ^ {7{m_al}};
            ui_in[7]   = ($urandom_range(0, 1) == 1);
            hld = $urandom_range(1, 12);
         end
         hld--;
         address = 4'($urandom_range(0, 15));
         data_in = 8'($urandom);
         data_write = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            address = 4'h4; data_write = 1'b1;
         end else if (r < 10) begin
            address = 4'h5; data_write = 1'b1;
         end else if (r < 12) begin
            address = 4'h1; data_in = 8'($urandom_range(0, 6)); data_write = 1'b1;
         end else if (r < 13) begin
            address = 4'h0; data_in[7] = ($urandom_range(0, 3) != 0); data_write = 1'b1;
         end else if (r < 14) begin
            address = 4'($urandom_range(6, 15)); data_write = 1'b1;
         end
         cyc(1'b0, 8'h00, "rnd");
         data_write = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
